alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single MainALU between two requesters: port 0 is the pipeline execute stage, port 1 is the auxiliary address/branch unit.
- Arbitrates between the requests, registers the winner's operands onto the ALU inputs and captures the ALU result one cycle later.
- Returns the result with a requester tag, and keeps a saturating overflow event counter.
- Sits between the EX-stage control and the ALU; the hazard unit can freeze it through a stall input.

Parameters:
DATA_W, 16, operand width; must equal the ALU input width.
PRIO_MODE, 0, 0 = round-robin between ports, 1 = fixed priority to port 0.
OVF_CNT_W, 8, width of the saturating overflow counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hazard-unit freeze; holds every pipeline register
req0_valid  input  1  port 0 request
req0_op  input  3  port 0 ALUControl code
req0_a  input  DATA_W  port 0 operand A
req0_b  input  DATA_W  port 0 operand B
req0_ready  output  1  port 0 request accepted this cycle
req1_valid, req1_op, req1_a, req1_b, req1_ready  same as port 0, for port 1
alu_a  output  DATA_W  registered operand A to the ALU
alu_b  output  DATA_W  registered operand B to the ALU
alu_ctrl  output  3  registered ALUControl to the ALU
alu_en  output  1  drives the ALU's active-low rst; 1 = ALU computes
alu_result  input  2*DATA_W  ALU Result (combinational)
alu_overflow  input  1  ALU Overflow (combinational)
resp_valid  output  1  response available
resp_id  output  1  requester of the response
resp_result  output  2*DATA_W  captured result
resp_overflow  output  1  captured overflow
ovf_count  output  OVF_CNT_W  count of consumed responses with overflow
ovf_clr  input  1  synchronous clear of ovf_count

Behaviour:
- Reset (async, any cycle): all outputs and registers go to 0, except last_id = 1 so port 0 wins first. Any in-flight operation is discarded and no response is produced for it.
- Grant (combinational):
  - If stall = 1, both ready signals are 0.
  - Otherwise, a single valid request is granted.
  - With both valid: PRIO_MODE = 1 grants port 0; PRIO_MODE = 0 grants the port != last_id.
  - Only one ready is ever high. ready never depends on resp_valid.
- Issue stage S1: on accept (valid & ready), the next edge loads:
  - alu_a, alu_b, alu_ctrl from the granted port;
  - s1_id = granted port;
  - s1_valid = 1;
  - last_id = granted port.
  - With no accept and stall = 0, s1_valid goes to 0 and the operand registers hold their values.
- alu_en = s1_valid. The ALU therefore outputs 0 when idle.
- Response stage S2: when stall = 0, the next edge loads resp_valid = s1_valid. If s1_valid = 1 it also loads resp_result = alu_result, resp_overflow = alu_overflow and resp_id = s1_id.
- Latency: request accepted in cycle N gives resp_valid in cycle N+2. Throughput is one request per cycle.
- Stall: S1, S2 and last_id all hold. resp_valid stays asserted with unchanged data. A response counts as consumed only in a cycle where resp_valid & !stall.
- ALU codes pass through unmodified, including 3'b110 and 3'b111. SWAP (3'b011) returns {A, B} in the 32-bit result.
- ovf_count:
  - increments by 1 on each consumed response with resp_overflow = 1;
  - saturates at all-ones;
  - ovf_clr takes priority over increment and clears it to 0 on the next edge.
- Simultaneous events:
  - accept and stall never coincide;
  - requests from both ports in the same cycle are resolved by arbitration, and the loser keeps valid asserted and holds its operands until it is granted.

Test Plan:
- Reset: assert rst mid-cycle with s1_valid = 1 -> all outputs 0 immediately; no resp_valid after release; first contested grant goes to port 0.
- Single ADD: port 0, op 000, A = 16'h0005, B = 16'h0003, accepted in cycle N -> cycle N+2: resp_valid = 1, resp_id = 0, resp_result = 32'h0000_0008, resp_overflow = 0.
- Round-robin: both ports valid for 4 cycles (PRIO_MODE = 0) -> grants 0, 1, 0, 1; responses tagged 0, 1, 0, 1 in order, back-to-back.
- Fixed priority: PRIO_MODE = 1, both valid for 3 cycles -> port 0 granted every cycle; req1_ready stays 0.
- Stall: stall = 1 for 2 cycles while a SWAP (A = 16'h1234, B = 16'h00AB) sits in S2 -> resp_valid held with resp_result = 32'h1234_00AB; no new grant; response consumed exactly once after stall drops.
- Overflow counter:
  - 3 consumed ADDs of 16'h8000 + 16'h8000 -> ovf_count = 3;
  - ovf_clr pulse -> ovf_count = 0;
  - force the counter to 8'hFF, then one more overflow -> ovf_count stays 8'hFF.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared MainALU. Port 0 is the EX stage and
// port 1 is the auxiliary address/branch unit. The winner's operands are
// registered onto the ALU inputs (S1). The ALU result is captured one cycle
// later (S2) and returned with a requester tag. A saturating counter tracks
// consumed overflowing responses.
module alu_arbiter #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned OVF_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  req0_valid,
    input  logic [2:0]            req0_op,
    input  logic [DATA_W-1:0]     req0_a,
    input  logic [DATA_W-1:0]     req0_b,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [2:0]            req1_op,
    input  logic [DATA_W-1:0]     req1_a,
    input  logic [DATA_W-1:0]     req1_b,
    output logic                  req1_ready,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [2:0]            alu_ctrl,
    output logic                  alu_en,
    input  logic [2*DATA_W-1:0]   alu_result,
    input  logic                  alu_overflow,
    output logic                  resp_valid,
    output logic                  resp_id,
    output logic [2*DATA_W-1:0]   resp_result,
    output logic                  resp_overflow,
    output logic [OVF_CNT_W-1:0]  ovf_count,
    input  logic                  ovf_clr
);

    logic                  r_last_id;
    logic                  r_s1_valid;
    logic                  r_s1_id;
    logic [DATA_W-1:0]     r_alu_a;
    logic [DATA_W-1:0]     r_alu_b;
    logic [2:0]            r_alu_ctrl;
    logic                  r_resp_valid;
    logic                  r_resp_id;
    logic [2*DATA_W-1:0]   r_resp_result;
    logic                  r_resp_overflow;
    logic [OVF_CNT_W-1:0]  r_ovf_count;

    logic                  w_prio_fixed;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_accept;
    logic                  w_consume;
    logic                  w_ovf_sat;

    assign w_prio_fixed = (PRIO_MODE == 1);

    // Grant: nothing while stalled; a lone request wins; a contest goes to
    // port 0 in fixed mode, otherwise to the port that did not win last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!stall) begin
            if (req0_valid && req1_valid) begin
                if (w_prio_fixed || r_last_id) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_accept   = w_gnt0 | w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Issue stage: load the winner's operands; operands hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_id  <= 1'b1;
            r_s1_valid <= 1'b0;
            r_s1_id    <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= '0;
        end else if (!stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_id    <= w_gnt1;
                r_last_id  <= w_gnt1;
                r_alu_a    <= w_gnt1 ? req1_a  : req0_a;
                r_alu_b    <= w_gnt1 ? req1_b  : req0_b;
                r_alu_ctrl <= w_gnt1 ? req1_op : req0_op;
            end
        end
    end

    // Response stage: capture the combinational ALU output behind S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid    <= 1'b0;
            r_resp_id       <= 1'b0;
            r_resp_result   <= '0;
            r_resp_overflow <= 1'b0;
        end else if (!stall) begin
            r_resp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_resp_id       <= r_s1_id;
                r_resp_result   <= alu_result;
                r_resp_overflow <= alu_overflow;
            end
        end
    end

    // A response is consumed in the single unstalled cycle it is visible.
    assign w_consume = r_resp_valid & ~stall;
    assign w_ovf_sat = (r_ovf_count == {OVF_CNT_W{1'b1}});

    // Saturating overflow event counter; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (ovf_clr) begin
            r_ovf_count <= '0;
        end else if (w_consume && r_resp_overflow && !w_ovf_sat) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_ctrl      = r_alu_ctrl;
    assign alu_en        = r_s1_valid;
    assign resp_valid    = r_resp_valid;
    assign resp_id       = r_resp_id;
    assign resp_result   = r_resp_result;
    assign resp_overflow = r_resp_overflow;
    assign ovf_count     = r_ovf_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance (dut) and a fixed
// priority instance (dut1) share the stimulus, each with its own ALU model.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        req0_valid;
    logic [2:0]  req0_op;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req1_valid;
    logic [2:0]  req1_op;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        ovf_clr;

    logic        req0_ready, req1_ready;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic        alu_en;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        resp_valid, resp_id, resp_overflow;
    logic [31:0] resp_result;
    logic [7:0]  ovf_count;

    logic        d1_req0_ready, d1_req1_ready;
    logic [15:0] d1_alu_a, d1_alu_b;
    logic [2:0]  d1_alu_ctrl;
    logic        d1_alu_en;
    logic [31:0] d1_alu_result;
    logic        d1_alu_overflow;
    logic        d1_resp_valid, d1_resp_id, d1_resp_overflow;
    logic [31:0] d1_resp_result;
    logic [7:0]  d1_ovf_count;

    logic [32:0] alu0_out;
    logic [32:0] alu1_out;

    int n_chk;
    int n_err;

    alu_arbiter #(.DATA_W(16), .PRIO_MODE(0), .OVF_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_en(alu_en),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
        .resp_overflow(resp_overflow), .ovf_count(ovf_count), .ovf_clr(ovf_clr)
    );

    alu_arbiter #(.DATA_W(16), .PRIO_MODE(1), .OVF_CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .stall(stall),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(d1_req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(d1_req1_ready),
        .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_ctrl(d1_alu_ctrl), .alu_en(d1_alu_en),
        .alu_result(d1_alu_result), .alu_overflow(d1_alu_overflow),
        .resp_valid(d1_resp_valid), .resp_id(d1_resp_id), .resp_result(d1_resp_result),
        .resp_overflow(d1_resp_overflow), .ovf_count(d1_ovf_count), .ovf_clr(ovf_clr)
    );

    // Stand-in for the MainALU: {overflow, result}; all zero while held in reset.
    function automatic logic [32:0] alu_f(input logic en, input logic [2:0] op,
                                          input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        logic        o;
        logic [16:0] s;
        r = '0;
        o = 1'b0;
        s = '0;
        if (en) begin
            case (op)
                3'b000: begin
                    s = {1'b0, a} + {1'b0, b};
                    r = {15'b0, s};
                    o = (a[15] == b[15]) && (s[15] != a[15]);
                end
                3'b001: begin
                    s = {1'b0, a} - {1'b0, b};
                    r = {16'b0, s[15:0]};
                    o = (a[15] != b[15]) && (s[15] != a[15]);
                end
                3'b010:  r = {16'b0, a & b};
                3'b011:  r = {a, b};
                3'b100:  r = {16'b0, a | b};
                3'b101:  r = {16'b0, a ^ b};
                3'b110:  r = {16'b0, a} * {16'b0, b};
                default: r = {31'b0, ($signed(a) < $signed(b))};
            endcase
        end
        return {o, r};
    endfunction

    always_comb alu0_out = alu_f(alu_en, alu_ctrl, alu_a, alu_b);
    always_comb alu1_out = alu_f(d1_alu_en, d1_alu_ctrl, d1_alu_a, d1_alu_b);
    assign alu_result      = alu0_out[31:0];
    assign alu_overflow    = alu0_out[32];
    assign d1_alu_result   = alu1_out[31:0];
    assign d1_alu_overflow = alu1_out[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic v, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b);
        req0_valid = v;
        req0_op    = op;
        req0_a     = a;
        req0_b     = b;
    endtask

    task automatic set1(input logic v, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b);
        req1_valid = v;
        req1_op    = op;
        req1_a     = a;
        req1_b     = b;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        stall = 1'b0;
        ovf_clr = 1'b0;
        set0(1'b0, 3'd0, 16'h0, 16'h0);
        set1(1'b0, 3'd0, 16'h0, 16'h0);
        tick();
        tick();

        // Reset state
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_alu_en", alu_en, 1'b0);
        chk("rst_alu_a", alu_a, 16'h0);
        chk("rst_alu_ctrl", alu_ctrl, 3'h0);
        chk("rst_resp_result", resp_result, 32'h0);
        chk("rst_ovf_count", ovf_count, 8'h0);
        rst = 1'b0;
        tick();

        // Single ADD from port 0
        set0(1'b1, 3'b000, 16'h0005, 16'h0003);
        #1;
        chk("add_ready0", req0_ready, 1'b1);
        chk("add_ready1", req1_ready, 1'b0);
        tick();
        set0(1'b0, 3'b000, 16'h0, 16'h0);
        chk("add_alu_en", alu_en, 1'b1);
        chk("add_alu_a", alu_a, 16'h0005);
        chk("add_n1_resp_valid", resp_valid, 1'b0);
        tick();
        chk("add_resp_valid", resp_valid, 1'b1);
        chk("add_resp_id", resp_id, 1'b0);
        chk("add_resp_result", resp_result, 32'h0000_0008);
        chk("add_resp_ovf", resp_overflow, 1'b0);
        tick();
        chk("add_resp_drop", resp_valid, 1'b0);
        chk("idle_alu_en", alu_en, 1'b0);

        // Codes 3'b110 / 3'b111 pass through from port 1
        set1(1'b1, 3'b111, 16'h0003, 16'h0005);
        tick();
        set1(1'b0, 3'b000, 16'h0, 16'h0);
        chk("op7_alu_ctrl", alu_ctrl, 3'b111);
        tick();
        chk("op7_resp_id", resp_id, 1'b1);
        chk("op7_resp_result", resp_result, 32'h0000_0001);
        set1(1'b1, 3'b110, 16'h0100, 16'h0100);
        tick();
        set1(1'b0, 3'b000, 16'h0, 16'h0);
        chk("op6_alu_ctrl", alu_ctrl, 3'b110);
        tick();
        chk("op6_resp_result", resp_result, 32'h0001_0000);
        tick();

        // Reset mid-cycle with an operation in S1 (last grant was port 1 here,
        // so issue a port-0 op to make last_id = 0 before reset)
        set0(1'b1, 3'b000, 16'h0007, 16'h0009);
        tick();
        set0(1'b0, 3'b000, 16'h0, 16'h0);
        chk("mid_s1_busy", alu_en, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_alu_en", alu_en, 1'b0);
        chk("mid_rst_alu_a", alu_a, 16'h0);
        chk("mid_rst_resp_valid", resp_valid, 1'b0);
        tick();
        chk("mid_rst_hold_resp", resp_valid, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_rst_no_resp", resp_valid, 1'b0);

        // Round-robin: both valid for 4 cycles, first contest goes to port 0
        set0(1'b1, 3'b000, 16'h0001, 16'h0002);
        set1(1'b1, 3'b000, 16'h000A, 16'h0014);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", req0_ready, (i % 2 == 0));
            chk("rr_ready1", req1_ready, (i % 2 == 1));
            tick();
            if (i >= 1) begin
                chk("rr_resp_valid", resp_valid, 1'b1);
                chk("rr_resp_id", resp_id, ((i - 1) % 2 == 1));
                chk("rr_resp_result", resp_result,
                    ((i - 1) % 2 == 1) ? 32'h0000_001E : 32'h0000_0003);
            end
        end
        set0(1'b0, 3'b000, 16'h0, 16'h0);
        set1(1'b0, 3'b000, 16'h0, 16'h0);
        tick();
        chk("rr_last_id", resp_id, 1'b1);
        chk("rr_last_result", resp_result, 32'h0000_001E);
        tick();
        chk("rr_drain", resp_valid, 1'b0);

        // Fixed priority instance: port 0 every cycle
        set0(1'b1, 3'b000, 16'h0002, 16'h0002);
        set1(1'b1, 3'b000, 16'h0030, 16'h0030);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fp_ready0", d1_req0_ready, 1'b1);
            chk("fp_ready1", d1_req1_ready, 1'b0);
            tick();
            if (i >= 1) begin
                chk("fp_resp_id", d1_resp_id, 1'b0);
            end
        end
        set0(1'b0, 3'b000, 16'h0, 16'h0);
        set1(1'b0, 3'b000, 16'h0, 16'h0);
        tick();
        tick();
        tick();

        // Stall while a SWAP sits in S2
        set0(1'b1, 3'b011, 16'h1234, 16'h00AB);
        tick();
        set0(1'b0, 3'b000, 16'h0, 16'h0);
        tick();
        chk("swap_resp_valid", resp_valid, 1'b1);
        chk("swap_resp_result", resp_result, 32'h1234_00AB);
        stall = 1'b1;
        set1(1'b1, 3'b000, 16'h0001, 16'h0001);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_ready0", req0_ready, 1'b0);
            chk("stall_ready1", req1_ready, 1'b0);
            tick();
            chk("stall_resp_valid", resp_valid, 1'b1);
            chk("stall_resp_result", resp_result, 32'h1234_00AB);
            chk("stall_no_issue", alu_en, 1'b0);
        end
        set1(1'b0, 3'b000, 16'h0, 16'h0);
        stall = 1'b0;
        tick();
        chk("stall_consumed_once", resp_valid, 1'b0);

        // Overflow counter: three consumed overflowing ADDs
        set0(1'b1, 3'b000, 16'h8000, 16'h8000);
        tick();
        tick();
        tick();
        set0(1'b0, 3'b000, 16'h0, 16'h0);
        chk("ovf_resp_flag", resp_overflow, 1'b1);
        chk("ovf_resp_result", resp_result, 32'h0001_0000);
        tick();
        tick();
        tick();
        chk("ovf_count3", ovf_count, 8'd3);
        tick();
        chk("ovf_count3_hold", ovf_count, 8'd3);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf_count, 8'd0);

        // Drive the counter to all-ones, then one more overflow
        set0(1'b1, 3'b000, 16'h8000, 16'h8000);
        for (int i = 0; i < 255; i++) begin
            tick();
        end
        set0(1'b0, 3'b000, 16'h0, 16'h0);
        tick();
        tick();
        tick();
        chk("ovf_count_ff", ovf_count, 8'hFF);
        set0(1'b1, 3'b000, 16'h8000, 16'h8000);
        tick();
        set0(1'b0, 3'b000, 16'h0, 16'h0);
        tick();
        chk("ovf_sat_resp", resp_overflow, 1'b1);
        tick();
        tick();
        chk("ovf_count_sat", ovf_count, 8'hFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
